// File: rtl/csr_access_if.sv
// Bundles the request, CSR-file and response signals of csr_access_unit.
// The unit uses the slave view; its environment (execute stage, CSR file, writeback) uses master.
interface csr_access_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [11:0] req_addr;
  logic [31:0] req_rs1_data;
  logic [4:0]  req_rs1_idx;
  logic [4:0]  req_rd_idx;
  logic [1:0]  priv_mode;
  logic        csr_en;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [4:0]  rsp_rd_idx;
  logic [31:0] rsp_rd_data;
  logic        rsp_rd_we;
  logic        rsp_exc;

  modport slave (
    input  req_valid, req_funct3, req_addr, req_rs1_data, req_rs1_idx, req_rd_idx, priv_mode,
    output req_ready,
    output csr_en, csr_op, csr_addr, csr_wdata,
    input  csr_rdata,
    output rsp_valid, rsp_rd_idx, rsp_rd_data, rsp_rd_we, rsp_exc,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_funct3, req_addr, req_rs1_data, req_rs1_idx, req_rd_idx, priv_mode,
    input  req_ready,
    input  csr_en, csr_op, csr_addr, csr_wdata,
    output csr_rdata,
    input  rsp_valid, rsp_rd_idx, rsp_rd_data, rsp_rd_we, rsp_exc,
    output rsp_ready
  );
endinterface

// File: rtl/csr_access_unit.sv
// Zicsr read-modify-write initiator: one instruction in flight, old value returned for rd.
// Optional privilege check on CSR address bits [9:8] enabled by defining CSR_PRIV_CHECK_EN.
//
// state | meaning
// IDLE  | ready for a new instruction
// READ  | CSR read strobe, old value captured
// WRITE | CSR write strobe with combined value
// RESP  | result held until writeback accepts
module csr_access_unit (
  input  logic        clk,
  input  logic        reset,
  csr_access_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

  localparam logic [1:0] KIND_RW = 2'b01;
  localparam logic [1:0] KIND_RS = 2'b10;

  state_t      state_q, state_d;
  logic [1:0]  kind_q, kind_d;
  logic [11:0] addr_q, addr_d;
  logic [31:0] src_q, src_d;
  logic [31:0] old_q, old_d;
  logic [4:0]  rd_q, rd_d;
  logic        do_write_q, do_write_d;
  logic        do_read_q, do_read_d;
  logic        exc_q, exc_d;

  logic [1:0]  req_kind;
  logic [31:0] req_src;
  logic        req_do_write, req_do_read, req_priv_exc, req_exc;

  logic        req_ready;
  logic        csr_en;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        rsp_valid, rsp_rd_we, rsp_exc;
  logic [4:0]  rsp_rd_idx;
  logic [31:0] rsp_rd_data;

`ifdef CSR_PRIV_CHECK_EN
  assign req_priv_exc = (bus.req_addr[9:8] > bus.priv_mode);
`else
  logic unused_priv;
  assign unused_priv  = ^bus.priv_mode;
  assign req_priv_exc = 1'b0;
`endif

  // funct3[1:0] selects RW/RS/RC; 00 is an illegal encoding for both register and immediate forms
  assign req_kind     = bus.req_funct3[1:0];
  assign req_src      = bus.req_funct3[2] ? {27'd0, bus.req_rs1_idx} : bus.req_rs1_data;
  assign req_do_write = (req_kind == KIND_RW) || (bus.req_rs1_idx != 5'd0);
  assign req_do_read  = !((req_kind == KIND_RW) && (bus.req_rd_idx == 5'd0));
  assign req_exc      = (req_kind == 2'b00) ||
                        (req_do_write && (bus.req_addr[11:10] == 2'b11)) ||
                        req_priv_exc;

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    addr_d     = addr_q;
    src_d      = src_q;
    old_d      = old_q;
    rd_d       = rd_q;
    do_write_d = do_write_q;
    do_read_d  = do_read_q;
    exc_d      = exc_q;

    req_ready   = 1'b0;
    csr_en      = 1'b0;
    csr_op      = 2'b00;
    csr_addr    = 12'd0;
    csr_wdata   = 32'd0;
    rsp_valid   = 1'b0;
    rsp_rd_we   = 1'b0;
    rsp_exc     = 1'b0;
    rsp_rd_idx  = 5'd0;
    rsp_rd_data = 32'd0;

    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          kind_d     = req_kind;
          addr_d     = bus.req_addr;
          src_d      = req_src;
          old_d      = 32'd0;
          rd_d       = bus.req_rd_idx;
          do_write_d = req_do_write;
          do_read_d  = req_do_read;
          exc_d      = req_exc;
          if (req_exc)          state_d = S_RESP;
          else if (req_do_read) state_d = S_READ;
          else                  state_d = S_WRITE;
        end
      end
      S_READ: begin
        csr_en   = 1'b1;
        csr_op   = 2'b01;
        csr_addr = addr_q;
        old_d    = bus.csr_rdata;
        state_d  = do_write_q ? S_WRITE : S_RESP;
      end
      S_WRITE: begin
        csr_en   = 1'b1;
        csr_op   = 2'b10;
        csr_addr = addr_q;
        case (kind_q)
          KIND_RW: csr_wdata = src_q;
          KIND_RS: csr_wdata = old_q | src_q;
          default: csr_wdata = old_q & ~src_q;
        endcase
        state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid   = 1'b1;
        rsp_exc     = exc_q;
        rsp_rd_idx  = rd_q;
        rsp_rd_data = old_q;
        rsp_rd_we   = !exc_q && do_read_q && (rd_q != 5'd0);
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      kind_q     <= 2'b00;
      addr_q     <= 12'd0;
      src_q      <= 32'd0;
      old_q      <= 32'd0;
      rd_q       <= 5'd0;
      do_write_q <= 1'b0;
      do_read_q  <= 1'b0;
      exc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      addr_q     <= addr_d;
      src_q      <= src_d;
      old_q      <= old_d;
      rd_q       <= rd_d;
      do_write_q <= do_write_d;
      do_read_q  <= do_read_d;
      exc_q      <= exc_d;
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.csr_en      = csr_en;
  assign bus.csr_op      = csr_op;
  assign bus.csr_addr    = csr_addr;
  assign bus.csr_wdata   = csr_wdata;
  assign bus.rsp_valid   = rsp_valid;
  assign bus.rsp_rd_we   = rsp_rd_we;
  assign bus.rsp_exc     = rsp_exc;
  assign bus.rsp_rd_idx  = rsp_rd_idx;
  assign bus.rsp_rd_data = rsp_rd_data;

endmodule

// File: tb/tb_csr_access_unit.sv
// Bench for csr_access_unit: directed cases plus random instructions checked against an
// instruction-level Zicsr model with its own copy of the CSR space.
module tb_csr_access_unit;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  csr_access_if bus();

  csr_access_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CSR file seen by the DUT: unwritten locations read an address-derived pattern
  bit [31:0] csr_mem [4096];
  bit        csr_wr  [4096];
  // model copy of the CSR space
  bit [31:0] ref_mem [4096];
  bit        ref_wr  [4096];

  function automatic logic [31:0] dflt(input logic [11:0] a);
    return {a, 8'hC3, a};
  endfunction

  always_comb bus.csr_rdata = csr_wr[bus.csr_addr] ? csr_mem[bus.csr_addr] : dflt(bus.csr_addr);

  always @(posedge clk) begin
    if (bus.csr_en && bus.csr_op == 2'b10) begin
      csr_mem[bus.csr_addr] <= bus.csr_wdata;
      csr_wr[bus.csr_addr]  <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, "_csr_en"},    32'(bus.csr_en), 32'd0);
    chk({tag, "_csr_op"},    32'(bus.csr_op), 32'd0);
    chk({tag, "_csr_addr"},  32'(bus.csr_addr), 32'd0);
    chk({tag, "_csr_wdata"}, bus.csr_wdata, 32'd0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_rsp_we"},    32'(bus.rsp_rd_we), 32'd0);
    chk({tag, "_rsp_exc"},   32'(bus.rsp_exc), 32'd0);
    chk({tag, "_rsp_idx"},   32'(bus.rsp_rd_idx), 32'd0);
    chk({tag, "_rsp_data"},  bus.rsp_rd_data, 32'd0);
  endtask

  task automatic ref_read(input logic [11:0] a, output logic [31:0] v);
    v = ref_wr[a] ? ref_mem[a] : dflt(a);
  endtask

  // Issue one instruction at posedge+1, follow it to completion, check against the model.
  task automatic run_instr(input logic [2:0] f3, input logic [11:0] addr,
                           input logic [31:0] rs1_data, input logic [4:0] rs1_idx,
                           input logic [4:0] rd, input logic [1:0] priv, input int hold);
    logic [31:0] src, old, nv, e_data, wval;
    logic        w, r, exc, e_we;
    int          e_lat, lat, nrd, nwr;
    logic [11:0] waddr, raddr;

    src = f3[2] ? {27'd0, rs1_idx} : rs1_data;
    ref_read(addr, old);
    w = 1'b0; r = 1'b0; nv = 32'd0; exc = 1'b0;
    case (f3)
      3'b001, 3'b101: begin w = 1'b1;             r = (rd != 0); nv = src;        end
      3'b010, 3'b110: begin w = (rs1_idx != 0);   r = 1'b1;      nv = old | src;  end
      3'b011, 3'b111: begin w = (rs1_idx != 0);   r = 1'b1;      nv = old & ~src; end
      default:        exc = 1'b1;
    endcase
    if (w && addr[11:10] == 2'b11) exc = 1'b1;
`ifdef CSR_PRIV_CHECK_EN
    if (addr[9:8] > priv) exc = 1'b1;
`endif
    e_lat  = exc ? 1 : ((r && w) ? 3 : 2);
    e_data = (!exc && r) ? old : 32'd0;
    e_we   = !exc && r && (rd != 0);
    if (!exc && w) begin
      ref_mem[addr] = nv;
      ref_wr[addr]  = 1'b1;
    end

    chk("ready_before_accept", 32'(bus.req_ready), 32'd1);
    bus.req_valid    = 1'b1;
    bus.req_funct3   = f3;
    bus.req_addr     = addr;
    bus.req_rs1_data = rs1_data;
    bus.req_rs1_idx  = rs1_idx;
    bus.req_rd_idx   = rd;
    bus.priv_mode    = priv;
    @(posedge clk); #1;
    // busy period: offer junk that must be ignored
    bus.req_funct3   = 3'($urandom);
    bus.req_addr     = 12'($urandom);
    bus.req_rs1_data = $urandom;
    bus.req_rs1_idx  = 5'($urandom);
    bus.req_rd_idx   = 5'($urandom);

    lat = 0; nrd = 0; nwr = 0; wval = 32'd0; waddr = 12'd0; raddr = 12'd0;
    for (int k = 1; k <= 8; k++) begin
      if (bus.csr_en && bus.csr_op == 2'b01) begin nrd++; raddr = bus.csr_addr; end
      if (bus.csr_en && bus.csr_op == 2'b10) begin nwr++; waddr = bus.csr_addr; wval = bus.csr_wdata; end
      if (bus.rsp_valid) begin lat = k; break; end
      @(posedge clk); #1;
    end
    chk("latency", lat, e_lat);
    chk("n_reads", nrd, (!exc && r) ? 1 : 0);
    chk("n_writes", nwr, (!exc && w) ? 1 : 0);
    if (nrd > 0) chk("read_addr", 32'(raddr), 32'(addr));
    if (!exc && w) begin
      chk("write_addr", 32'(waddr), 32'(addr));
      chk("write_data", wval, nv);
    end
    if (lat == 0) begin
      reset = 1'b1; bus.req_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      return;
    end
    chk("rsp_exc", 32'(bus.rsp_exc), 32'(exc));
    chk("rsp_rd_data", bus.rsp_rd_data, e_data);
    chk("rsp_rd_we", 32'(bus.rsp_rd_we), 32'(e_we));
    chk("rsp_rd_idx", 32'(bus.rsp_rd_idx), 32'(rd));

    for (int h = 0; h < hold; h++) begin
      bus.rsp_ready = 1'b0;
      @(posedge clk); #1;
      chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold_data", bus.rsp_rd_data, e_data);
      chk("hold_we", 32'(bus.rsp_rd_we), 32'(e_we));
      chk("hold_no_csr", 32'(bus.csr_en), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    chk("ready_after_done", 32'(bus.req_ready), 32'd1);
    chk("valid_after_done", 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    logic [11:0] addr_pool [8];
    logic [11:0] a;
    logic [1:0]  pr;
    logic [31:0] v;

    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr = 12'd0;
    bus.req_rs1_data = 32'd0;
    bus.req_rs1_idx = 5'd0;
    bus.req_rd_idx = 5'd0;
    bus.priv_mode = 2'b11;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    run_instr(3'b001, 12'h300, 32'h0000_00A0, 5'd7, 5'd0, 2'b11, 0);  // CSRRW rd=0 preload
    run_instr(3'b010, 12'h300, 32'h0000_000F, 5'd3, 5'd5, 2'b11, 0);  // CSRRS -> old A0, write AF
    run_instr(3'b001, 12'h340, 32'h0000_00FF, 5'd9, 5'd0, 2'b11, 0);
    run_instr(3'b111, 12'h340, 32'd0, 5'd3, 5'd0, 2'b11, 0);          // CSRRCI -> FC
    run_instr(3'b110, 12'h340, 32'd0, 5'd0, 5'd2, 2'b11, 0);          // CSRRSI uimm=0, read only
    run_instr(3'b001, 12'h341, 32'h0000_1234, 5'd4, 5'd0, 2'b11, 0);  // CSRRW write only
    run_instr(3'b001, 12'hF11, 32'h5555_5555, 5'd4, 5'd1, 2'b11, 0);  // write to read-only
    run_instr(3'b010, 12'hF11, 32'hFFFF_FFFF, 5'd0, 5'd3, 2'b11, 0);  // legal read of read-only
    run_instr(3'b010, 12'h300, 32'd0, 5'd0, 5'd4, 2'b00, 0);          // U-mode read of M CSR
    run_instr(3'b000, 12'h100, 32'd1, 5'd1, 5'd1, 2'b11, 0);
    run_instr(3'b100, 12'h100, 32'd1, 5'd1, 5'd1, 2'b11, 0);
    run_instr(3'b011, 12'h300, 32'h0000_0003, 5'd6, 5'd8, 2'b11, 5);  // long writeback stall

    // reset while in WRITE; the write is old|0 so the CSR value is the same either way
    bus.req_valid    = 1'b1;
    bus.req_funct3   = 3'b010;
    bus.req_addr     = 12'h300;
    bus.req_rs1_data = 32'd0;
    bus.req_rs1_idx  = 5'd5;
    bus.req_rd_idx   = 5'd1;
    bus.priv_mode    = 2'b11;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_reached_write", 32'(bus.csr_op), 32'd2);
    reset = 1'b1;
    @(posedge clk); #1;
    chk_idle_outputs("rst_in_write");
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("no_rsp_after_abort", 32'(bus.rsp_valid), 32'd0);
    end

    addr_pool[0] = 12'h300; addr_pool[1] = 12'h341; addr_pool[2] = 12'hF11; addr_pool[3] = 12'hC00;
    addr_pool[4] = 12'h100; addr_pool[5] = 12'h000; addr_pool[6] = 12'h7C0; addr_pool[7] = 12'h200;
    for (int n = 0; n < 200; n++) begin
      a  = ($urandom_range(0, 3) == 0) ? 12'($urandom) : addr_pool[$urandom_range(0, 7)];
      pr = ($urandom_range(0, 2) == 0) ? 2'b00 : (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11);
      run_instr(3'($urandom), a, $urandom,
                ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                pr, $urandom_range(0, 2));
    end

    // the CSR file contents must match the model where either side wrote
    for (int i = 0; i < 4096; i++) begin
      if (ref_wr[i] || csr_wr[i]) begin
        ref_read(12'(i), v);
        chk("final_csr", bus.csr_wdata == 32'd0 ? (csr_wr[i] ? csr_mem[i] : dflt(12'(i))) : 32'hDEAD_BEEF, v);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csr_access_unit.md
# csr_access_unit

CSR access initiator sitting between the execute stage and the CSR register file. Accepts one decoded Zicsr instruction per handshake and performs the read-modify-write sequence on the CSR file's `csr_en`/`csr_op`/`csr_addr`/`csr_wdata`/`csr_rdata` port. Returns the old CSR value for rd writeback, or flags an illegal-instruction exception. One instruction is in flight at a time.

## Interface
- No parameters; data width fixed at 32.
- `clk`  in  1  sole clock
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  1  instruction offered
- `req_ready`  out  1  unit idle, can accept
- `req_funct3`  in  3  001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
- `req_addr`  in  12  CSR address
- `req_rs1_data`  in  32  rs1 value (register forms)
- `req_rs1_idx`  in  5  rs1 index / uimm[4:0] (immediate forms)
- `req_rd_idx`  in  5  destination register
- `priv_mode`  in  2  current privilege (00 U, 01 S, 11 M)
- `csr_en`  out  1  CSR file access strobe
- `csr_op`  out  2  00 none, 01 read, 10 write
- `csr_addr`  out  12  CSR address
- `csr_wdata`  out  32  write value
- `csr_rdata`  in  32  CSR file read data, valid combinationally in the read cycle
- `rsp_valid`  out  1  result available
- `rsp_ready`  in  1  writeback accepts result
- `rsp_rd_idx`  out  5  destination register
- `rsp_rd_data`  out  32  old CSR value
- `rsp_rd_we`  out  1  rd write enable
- `rsp_exc`  out  1  illegal-instruction exception

## Operation
- States: IDLE, READ, WRITE, RESP.
- `req_ready` = (state == IDLE). Request fields latched on `req_valid & req_ready`.
- src = funct3[2] ? zero-extended `req_rs1_idx` : `req_rs1_data`.
- do_write = RW/RWI always; RS/RC/RSI/RCI only if `req_rs1_idx` != 0.
- do_read = true unless RW/RWI with `req_rd_idx` == 0.
- Exception at accept if any of: funct3 ∈ {000, 100}; do_write with `req_addr[11:10]` == 2'b11; privilege violation (see Configuration).
- Transitions on accept: exc → RESP; else do_read → READ; else → WRITE.
- READ: `csr_en`=1, `csr_op`=01; capture `csr_rdata` into old; → WRITE if do_write, else RESP.
- WRITE: `csr_en`=1, `csr_op`=10, `csr_wdata` = RW: src; RS: old | src; RC: old & ~src; → RESP.
- RESP: `rsp_valid`=1; `rsp_rd_we` = !exc & do_read & (rd != 0); `rsp_rd_data` = old (0 when not read or on exception); hold all rsp outputs stable until `rsp_ready`, then → IDLE.
- `csr_addr` driven with latched address in READ/WRITE, 0 otherwise; `csr_wdata` 0 outside WRITE.
- No CSR access issued for an excepting instruction.

## Timing
- Reset: state IDLE; `req_ready`=1; `csr_en`=0, `csr_op`=00, `csr_addr`=0, `csr_wdata`=0; `rsp_valid`=0, `rsp_rd_we`=0, `rsp_exc`=0, `rsp_rd_idx`=0, `rsp_rd_data`=0.
- Accept at edge N. Read+write: READ N+1, WRITE N+2, `rsp_valid` N+3. Read-only or write-only: `rsp_valid` N+2. Exception: `rsp_valid` N+1.
- `rsp_valid & rsp_ready` at edge M → `req_ready`=1 from M; next accept no earlier than M+1 (no same-cycle accept/complete).
- `rsp_ready` low holds RESP indefinitely; no CSR traffic meanwhile.
- Reset in any state → IDLE at that edge; a WRITE cycle coincident with reset is not guaranteed to commit; no `rsp_valid` produced for the aborted instruction.
- `req_*` inputs are ignored whenever `req_ready`=0.

## Configuration
- `CSR_PRIV_CHECK_EN` defined: exception also raised when `req_addr[9:8]` > `priv_mode` (unsigned compare), for read or write.
- Undefined: no privilege check; only funct3 and read-only-write checks apply; `priv_mode` unused.

## Test plan
- CSRRS rd=5, rs1_idx=3, rs1_data=0x0F, addr 0x300 holding 0xA0 → READ returns 0xA0, WRITE `csr_wdata`=0xAF, `rsp_rd_data`=0xA0, `rsp_rd_we`=1, `rsp_valid` 3 cycles after accept.
- CSRRCI rd=0, uimm=0x03, CSR 0xFF → read issued, write 0xFC, `rsp_rd_we`=0; CSRRSI uimm=0 → no WRITE cycle, `rsp_valid` at accept+2.
- CSRRW rd=0, rs1_data=0x1234 → no READ cycle, single WRITE of 0x1234, `rsp_rd_data`=0, `rsp_valid` at accept+2.
- CSRRW to 0xF11 → `rsp_exc`=1 at accept+1, `csr_en` never asserted; CSRRS rs1_idx=0 to 0xF11 → legal read, no exception.
- With `CSR_PRIV_CHECK_EN`, `priv_mode`=00 reading 0x300 → `rsp_exc`=1; without macro → normal read.
- Hold `rsp_ready`=0 for 5 cycles then pulse; assert `reset` during WRITE → all outputs return to reset values next cycle, `req_ready`=1.
